// File: rtl/red_pitaya_spi_responder.sv
// SPI responder for the 16-bit {R/W, ADR[6:0]} + data config frame. It keeps an 8-bit register file,
// pulses a strobe on each committed write and returns register data on reads. All SPI pins are oversampled in clk_i.
module red_pitaya_spi_responder #(
    parameter int NREG     = 8,
    parameter bit CLK_IDLE = 1'b1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                spi_cs_i,
    input  logic                spi_clk_i,
    input  logic                spi_mosi_i,
    output logic                spi_miso_o,
    output logic                spi_miso_t,
    output logic [NREG*8-1:0]   reg_o,
    output logic                wr_o,
    output logic [6:0]          wr_adr_o,
    output logic [7:0]          wr_dat_o,
    output logic [15:0]         frm_cnt_o,
    output logic [15:0]         err_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;
    localparam logic [7:0] NREG_W   = 8'(NREG);

    function automatic logic adr_in_range(input logic [6:0] adr);
        return ({1'b0, adr} < NREG_W);
    endfunction

    logic [2:0]          cs_sync_r;
    logic [2:0]          sclk_sync_r;
    logic [1:0]          mosi_sync_r;
    logic [1:0]          state_r;
    logic [4:0]          bit_cnt_r;
    logic [15:0]         sh_r;
    logic [7:0]          tx_r;
    logic                cs_fall_pend_r;
    logic                miso_r;
    logic                miso_t_r;
    logic [NREG*8-1:0]   reg_r;
    logic                wr_r;
    logic [6:0]          wr_adr_r;
    logic [7:0]          wr_dat_r;
    logic [15:0]         frm_cnt_r;
    logic [15:0]         err_cnt_r;

    logic                cs_fall_s;
    logic                cs_rise_s;
    logic                sclk_rise_s;
    logic                sclk_fall_s;
    logic                mosi_s;
    logic                hdr_rw_s;
    logic [6:0]          hdr_adr_s;
    logic [7:0]          rd_byte_s;

    // Two-stage synchronisers plus one history stage; SCLK resets to its idle level so no false edge follows reset.
    // CS resets low so a frame already in flight at reset release produces no falling edge and is discarded.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cs_sync_r   <= 3'b000;
            sclk_sync_r <= {3{CLK_IDLE}};
            mosi_sync_r <= 2'b00;
        end else begin
            cs_sync_r   <= {cs_sync_r[1:0], spi_cs_i};
            sclk_sync_r <= {sclk_sync_r[1:0], spi_clk_i};
            mosi_sync_r <= {mosi_sync_r[0], spi_mosi_i};
        end
    end

    assign cs_fall_s   = cs_sync_r[2] & ~cs_sync_r[1];
    assign cs_rise_s   = ~cs_sync_r[2] & cs_sync_r[1];
    assign sclk_rise_s = ~sclk_sync_r[2] & sclk_sync_r[1];
    assign sclk_fall_s = sclk_sync_r[2] & ~sclk_sync_r[1];
    assign mosi_s      = mosi_sync_r[1];

    // Header as it will look after the 8th rising edge: shift register plus the bit being sampled now.
    assign hdr_rw_s  = sh_r[6];
    assign hdr_adr_s = {sh_r[5:0], mosi_s};

    // Read mux; out-of-range addresses match no register and return zero.
    always_comb begin
        rd_byte_s = 8'h00;
        for (int k = 0; k < NREG; k++) begin
            rd_byte_s = rd_byte_s | ((hdr_adr_s == 7'(k)) ? reg_r[k*8 +: 8] : 8'h00);
        end
    end

    // Frame FSM, read shifter, register file and counters.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r        <= ST_IDLE;
            bit_cnt_r      <= 5'd0;
            sh_r           <= 16'h0000;
            tx_r           <= 8'h00;
            cs_fall_pend_r <= 1'b0;
            miso_r         <= 1'b0;
            miso_t_r       <= 1'b1;
            reg_r          <= '0;
            wr_r           <= 1'b0;
            wr_adr_r       <= 7'h00;
            wr_dat_r       <= 8'h00;
            frm_cnt_r      <= 16'h0000;
            err_cnt_r      <= 16'h0000;
        end else begin
            wr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cs_fall_pend_r <= 1'b0;
                    if (cs_fall_s || cs_fall_pend_r) begin
                        bit_cnt_r <= 5'd0;
                        sh_r      <= 16'h0000;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // CS rising takes priority over any SCLK edge seen in the same cycle.
                    if (cs_rise_s) begin
                        state_r <= ST_END;
                    end else if (sclk_rise_s) begin
                        sh_r <= {sh_r[14:0], mosi_s};
                        if (bit_cnt_r != 5'd17) begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                        if (bit_cnt_r == 5'd7) begin
                            if (hdr_rw_s) begin
                                tx_r     <= rd_byte_s;
                                miso_t_r <= 1'b0;
                            end else begin
                                tx_r <= 8'h00;
                            end
                        end
                    end else if (sclk_fall_s && (bit_cnt_r >= 5'd8) && (bit_cnt_r <= 5'd15)) begin
                        miso_r <= tx_r[7];
                        tx_r   <= {tx_r[6:0], 1'b0};
                    end
                end
                ST_END: begin
                    miso_t_r       <= 1'b1;
                    state_r        <= ST_IDLE;
                    cs_fall_pend_r <= cs_fall_s;
                    // A complete frame leaves the header in sh_r[15:8] and the data byte in sh_r[7:0].
                    if ((bit_cnt_r == 5'd16) && sh_r[15]) begin
                        frm_cnt_r <= frm_cnt_r + 16'd1;
                    end else if ((bit_cnt_r == 5'd16) && adr_in_range(sh_r[14:8])) begin
                        for (int k = 0; k < NREG; k++) begin
                            if (sh_r[14:8] == 7'(k)) begin
                                reg_r[k*8 +: 8] <= sh_r[7:0];
                            end
                        end
                        wr_r      <= 1'b1;
                        wr_adr_r  <= sh_r[14:8];
                        wr_dat_r  <= sh_r[7:0];
                        frm_cnt_r <= frm_cnt_r + 16'd1;
                    end else begin
                        err_cnt_r <= err_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_miso_o = miso_r;
    assign spi_miso_t = miso_t_r;
    assign reg_o      = reg_r;
    assign wr_o       = wr_r;
    assign wr_adr_o   = wr_adr_r;
    assign wr_dat_o   = wr_dat_r;
    assign frm_cnt_o  = frm_cnt_r;
    assign err_cnt_o  = err_cnt_r;

endmodule

// File: tb/tb_red_pitaya_spi_responder.sv
// Bench for red_pitaya_spi_responder: a table of directed frames, randomized frames against a register-file model,
// and hand sequences for reset mid-frame, back-to-back frames and write latency.
module tb_red_pitaya_spi_responder;

    localparam int NREG = 8;
    localparam int HALF = 6;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cs = 1'b1;
    logic              sclk = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic              miso_t;
    logic [NREG*8-1:0] reg_o;
    logic              wr;
    logic [6:0]        wr_adr;
    logic [7:0]        wr_dat;
    logic [15:0]       frm_cnt;
    logic [15:0]       err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_seen = 0;

    logic [7:0]  m_reg [NREG];
    logic [15:0] m_frm;
    logic [15:0] m_err;
    logic [6:0]  m_wadr;
    logic [7:0]  m_wdat;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic        exp_wr;
        logic [7:0]  exp_miso;
        logic [15:0] exp_frm;
        logic [15:0] exp_err;
        logic [63:0] exp_reg;
        logic [6:0]  exp_wadr;
        logic [7:0]  exp_wdat;
    } vec_t;

    vec_t tbl [11];

    red_pitaya_spi_responder #(.NREG(NREG), .CLK_IDLE(1'b1)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .spi_cs_i   (cs),
        .spi_clk_i  (sclk),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .spi_miso_t (miso_t),
        .reg_o      (reg_o),
        .wr_o       (wr),
        .wr_adr_o   (wr_adr),
        .wr_dat_o   (wr_dat),
        .frm_cnt_o  (frm_cnt),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr === 1'b1) wr_seen <= wr_seen + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] m_reg_o();
        logic [63:0] v = 64'h0;
        for (int k = 0; k < NREG; k++) v[k*8 +: 8] = m_reg[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_reg[k] = 8'h00;
        m_frm = 16'h0; m_err = 16'h0; m_wadr = 7'h0; m_wdat = 8'h0;
    endtask

    // Frame semantics: exactly 16 bits is good; reads always count, writes only hit existing registers.
    task automatic model_frame(input logic [15:0] word, input int nbits,
                               output logic exp_wr, output logic [7:0] exp_miso);
        int adr = int'(word[14:8]);
        exp_wr = 1'b0;
        exp_miso = 8'h00;
        if (nbits != 16) begin
            m_err = m_err + 16'd1;
        end else if (word[15]) begin
            exp_miso = (adr < NREG) ? m_reg[adr] : 8'h00;
            m_frm = m_frm + 16'd1;
        end else if (adr < NREG) begin
            m_reg[adr] = word[7:0];
            m_wadr = word[14:8];
            m_wdat = word[7:0];
            m_frm = m_frm + 16'd1;
            exp_wr = 1'b1;
        end else begin
            m_err = m_err + 16'd1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        wait_clk(4);
        rstn = 1'b1;
        wait_clk(8);
        model_reset();
    endtask

    // One SCLK period in mode CLK_IDLE=1: falling edge drives MOSI, MISO is sampled just before the rising edge.
    task automatic send_bit(input logic b, output logic m, output logic t);
        sclk = 1'b0;
        mosi = b;
        wait_clk(HALF);
        m = miso;
        t = miso_t;
        sclk = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic do_frame(input logic [15:0] word, input int nbits, input int gap,
                            output logic [15:0] rx, output logic [31:0] tl);
        logic m, t;
        rx = 16'h0;
        tl = 32'h0;
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 1; i <= nbits; i++) begin
            send_bit((i <= 16) ? word[16-i] : 1'b0, m, t);
            rx = {rx[14:0], m};
            tl[i-1] = ~t;
        end
        cs = 1'b1;
        mosi = 1'b0;
        wait_clk(gap);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] word, input int nbits,
                             input logic exp_wr, input logic [7:0] exp_miso,
                             input logic [15:0] exp_frm, input logic [15:0] exp_err,
                             input logic [63:0] exp_reg, input logic [6:0] exp_wadr,
                             input logic [7:0] exp_wdat);
        logic [15:0] rx;
        logic [31:0] tl;
        int w0 = wr_seen;
        do_frame(word, nbits, 8, rx, tl);
        chk({tag, "_wr_pulses"}, 64'(wr_seen - w0), 64'(exp_wr));
        chk({tag, "_frm_cnt"}, 64'(frm_cnt), 64'(exp_frm));
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
        chk({tag, "_reg_o"}, reg_o, exp_reg);
        chk({tag, "_wr_adr"}, 64'(wr_adr), 64'(exp_wadr));
        chk({tag, "_wr_dat"}, 64'(wr_dat), 64'(exp_wdat));
        chk({tag, "_miso_t_idle"}, 64'(miso_t), 64'h1);
        if (nbits == 16 && word[15]) begin
            chk({tag, "_miso_data"}, 64'(rx[7:0]), 64'(exp_miso));
            chk({tag, "_miso_t_window"}, 64'(tl), 64'h0000_FF00);
        end else if (nbits == 16) begin
            chk({tag, "_miso_t_window"}, 64'(tl), 64'h0);
        end
    endtask

    initial begin
        logic        ew;
        logic [7:0]  em;
        logic [15:0] w;
        logic [15:0] rx;
        logic [31:0] tl;
        logic        m, t;
        int          nb;
        int          w0;

        tbl[0]  = '{16'h02A5, 16, 1'b1, 8'h00, 16'd1, 16'd0, 64'h0000_0000_00A5_0000, 7'h02, 8'hA5};
        tbl[1]  = '{16'h8200, 16, 1'b0, 8'hA5, 16'd2, 16'd0, 64'h0000_0000_00A5_0000, 7'h02, 8'hA5};
        tbl[2]  = '{16'h0377, 12, 1'b0, 8'h00, 16'd2, 16'd1, 64'h0000_0000_00A5_0000, 7'h02, 8'hA5};
        tbl[3]  = '{16'h0377, 17, 1'b0, 8'h00, 16'd2, 16'd2, 64'h0000_0000_00A5_0000, 7'h02, 8'hA5};
        tbl[4]  = '{16'h1055, 16, 1'b0, 8'h00, 16'd2, 16'd3, 64'h0000_0000_00A5_0000, 7'h02, 8'hA5};
        tbl[5]  = '{16'h9000, 16, 1'b0, 8'h00, 16'd3, 16'd3, 64'h0000_0000_00A5_0000, 7'h02, 8'hA5};
        tbl[6]  = '{16'h07C3, 16, 1'b1, 8'h00, 16'd4, 16'd3, 64'hC300_0000_00A5_0000, 7'h07, 8'hC3};
        tbl[7]  = '{16'h8700, 16, 1'b0, 8'hC3, 16'd5, 16'd3, 64'hC300_0000_00A5_0000, 7'h07, 8'hC3};
        tbl[8]  = '{16'h7F01, 16, 1'b0, 8'h00, 16'd5, 16'd4, 64'hC300_0000_00A5_0000, 7'h07, 8'hC3};
        tbl[9]  = '{16'h00FF, 16, 1'b1, 8'h00, 16'd6, 16'd4, 64'hC300_0000_00A5_00FF, 7'h00, 8'hFF};
        tbl[10] = '{16'h8000, 16, 1'b0, 8'hFF, 16'd7, 16'd4, 64'hC300_0000_00A5_00FF, 7'h00, 8'hFF};

        do_reset();
        chk("rst_miso_t", 64'(miso_t), 64'h1);
        chk("rst_miso", 64'(miso), 64'h0);
        chk("rst_reg_o", reg_o, 64'h0);
        chk("rst_wr", 64'(wr), 64'h0);
        chk("rst_frm", 64'(frm_cnt), 64'h0);
        chk("rst_err", 64'(err_cnt), 64'h0);
        chk("rst_wr_adr", 64'(wr_adr), 64'h0);
        chk("rst_wr_dat", 64'(wr_dat), 64'h0);

        for (int i = 0; i < 11; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].word, tbl[i].nbits, tbl[i].exp_wr, tbl[i].exp_miso,
                      tbl[i].exp_frm, tbl[i].exp_err, tbl[i].exp_reg, tbl[i].exp_wadr, tbl[i].exp_wdat);
        end

        do_reset();
        for (int i = 0; i < 40; i++) begin
            w = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 11)), 8'($urandom)};
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 17)) : 16;
            model_frame(w, nb, ew, em);
            run_frame($sformatf("rnd%0d", i), w, nb, ew, em, m_frm, m_err, m_reg_o(), m_wadr, m_wdat);
        end

        // Reset after bit 10 of a write to register 1; the rest of that frame must be discarded.
        do_reset();
        w0 = wr_seen;
        w = 16'h013C;
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 1; i <= 10; i++) send_bit(w[16-i], m, t);
        rstn = 1'b0;
        wait_clk(2);
        chk("rmid_miso_t", 64'(miso_t), 64'h1);
        chk("rmid_miso", 64'(miso), 64'h0);
        chk("rmid_reg_o", reg_o, 64'h0);
        chk("rmid_frm", 64'(frm_cnt), 64'h0);
        chk("rmid_err", 64'(err_cnt), 64'h0);
        chk("rmid_wr_adr", 64'(wr_adr), 64'h0);
        chk("rmid_wr_dat", 64'(wr_dat), 64'h0);
        rstn = 1'b1;
        for (int i = 11; i <= 16; i++) send_bit(w[16-i], m, t);
        cs = 1'b1;
        wait_clk(8);
        chk("rmid_discard_wr", 64'(wr_seen - w0), 64'h0);
        chk("rmid_discard_err", 64'(err_cnt), 64'h0);
        chk("rmid_discard_frm", 64'(frm_cnt), 64'h0);
        model_reset();
        model_frame(w, 16, ew, em);
        run_frame("rmid_next", w, 16, ew, em, m_frm, m_err, m_reg_o(), m_wadr, m_wdat);

        // Back-to-back writes with CS high for only two clk_i cycles.
        do_reset();
        w0 = wr_seen;
        do_frame(16'h0011, 16, 2, rx, tl);
        model_frame(16'h0011, 16, ew, em);
        do_frame(16'h0122, 16, 8, rx, tl);
        model_frame(16'h0122, 16, ew, em);
        chk("b2b_wr_pulses", 64'(wr_seen - w0), 64'h2);
        chk("b2b_frm", 64'(frm_cnt), 64'h2);
        chk("b2b_err", 64'(err_cnt), 64'h0);
        chk("b2b_reg_o", reg_o, m_reg_o());

        // Commit latency: wr_o high exactly on the 4th clk_i edge after raw CS rises.
        do_frame(16'h0466, 16, 0, rx, tl);
        repeat (4) @(negedge clk);
        chk("lat_wr_early", 64'(wr), 64'h0);
        @(negedge clk);
        chk("lat_wr_pulse", 64'(wr), 64'h1);
        chk("lat_wr_dat", 64'(wr_dat), 64'h66);
        chk("lat_reg4", 64'(reg_o[39:32]), 64'h66);
        @(negedge clk);
        chk("lat_wr_drop", 64'(wr), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
